// File: rtl/enc_onehot_decoder.sv
// Registered binary-to-one-hot decoder with enable, valid/ready input and a
// free-running scan sweep that holds each code for DWELL cycles.
module enc_onehot_decoder #(
  parameter int SEL_W = 2,
  parameter int DWELL = 4,
  localparam int OUT_W = 2**SEL_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             mode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SEL_W-1:0] sel,
  output logic [OUT_W-1:0] out,
  output logic             out_valid,
  output logic [SEL_W-1:0] scan_idx,
  output logic             busy
);

  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DIRECT = 2'd1;
  localparam logic [1:0] SCAN   = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [OUT_W-1:0] out_q, out_d;
  logic [SEL_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             xfer;

  // Blocking ready while in SCAN drops the sel offered on the scan-exit edge.
  assign in_ready = enable & ~mode & ~rst & (state_q != SCAN);
  assign xfer     = in_valid & in_ready;

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    if (!enable) begin
      state_d = IDLE;
      out_d   = '0;
      idx_d   = '0;
      cnt_d   = '0;
    end else if (mode && state_q != SCAN) begin
      state_d = SCAN;
      out_d   = OUT_W'(1);
      idx_d   = '0;
      cnt_d   = '0;
    end else if (state_q == SCAN && mode) begin
      if (cnt_q == CNT_LAST) begin
        // Index width is exactly SEL_W, so the increment wraps OUT_W-1 -> 0.
        cnt_d = '0;
        idx_d = idx_q + SEL_W'(1);
        out_d = OUT_W'(1) << (idx_q + SEL_W'(1));
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (state_q == SCAN) begin
      state_d = IDLE;
      out_d   = '0;
      idx_d   = '0;
      cnt_d   = '0;
    end else if (xfer) begin
      state_d = DIRECT;
      out_d   = OUT_W'(1) << sel;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      out_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out       = out_q;
  assign out_valid = |out_q;
  assign scan_idx  = idx_q;
  assign busy      = (state_q == SCAN);

endmodule

// File: tb/tb_enc_onehot_decoder.sv
// Directed bench for enc_onehot_decoder (SEL_W=2, DWELL=4) with a
// cycle-count based reference model compared on every falling edge.
module tb_enc_onehot_decoder;
  localparam int SEL_W = 2;
  localparam int DWELL = 4;
  localparam int OUT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             enable = 1'b0;
  logic             mode = 1'b0;
  logic             in_valid = 1'b0;
  logic [SEL_W-1:0] sel = '0;
  logic             in_ready;
  logic [OUT_W-1:0] out;
  logic             out_valid;
  logic [SEL_W-1:0] scan_idx;
  logic             busy;

  int n_cmp = 0;
  int n_err = 0;

  enc_onehot_decoder #(.SEL_W(SEL_W), .DWELL(DWELL)) dut (
    .clk(clk), .rst(rst), .enable(enable), .mode(mode),
    .in_valid(in_valid), .in_ready(in_ready), .sel(sel),
    .out(out), .out_valid(out_valid), .scan_idx(scan_idx), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference: scan position is elapsed edges since scan entry divided by DWELL.
  bit m_scan = 0;
  int m_k    = 0;
  int m_out  = 0;
  int m_sel  = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_scan = 0; m_k = 0; m_out = 0;
    end else if (!enable) begin
      m_scan = 0; m_out = 0;
    end else if (mode) begin
      if (!m_scan) begin m_scan = 1; m_k = 0; end
      else m_k = m_k + 1;
      m_out = 1 << ((m_k / DWELL) % OUT_W);
    end else if (m_scan) begin
      m_scan = 0; m_out = 0;
    end else if (in_valid) begin
      m_sel = int'(sel);
      m_out = 1 << m_sel;
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("model_out", int'(out), m_out);
    chk("model_out_valid", int'(out_valid), int'(m_out != 0));
    chk("model_scan_idx", int'(scan_idx), m_scan ? (m_k / DWELL) % OUT_W : 0);
    chk("model_busy", int'(busy), int'(m_scan));
    chk("model_in_ready", int'(in_ready),
        int'(enable & ~mode & ~rst & ~m_scan));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] exp_dir [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

  initial begin
    rst = 1'b1;
    step(); step();
    chk("reset_out", int'(out), 0);
    chk("reset_in_ready", int'(in_ready), 0);
    rst = 1'b0;
    step();

    // direct decode, back-to-back transfers
    enable = 1'b1; mode = 1'b0; in_valid = 1'b1;
    for (int s = 0; s < 4; s++) begin
      sel = SEL_W'(s);
      step();
      chk("direct_out", int'(out), int'(exp_dir[s]));
      chk("direct_valid", int'(out_valid), 1);
    end

    // enable=0 wins over a pending transfer
    enable = 1'b0; sel = 2'd2;
    #1;
    chk("dis_in_ready", int'(in_ready), 0);
    step();
    chk("dis_out", int'(out), 0);
    chk("dis_valid", int'(out_valid), 0);
    enable = 1'b1; sel = 2'd1;
    step();
    chk("reen_out", int'(out), 4'b0010);

    // hold without transfers
    sel = 2'd3;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hold_out", int'(out), 4'b1000);
    end

    // async reset mid-direct
    in_valid = 1'b1; sel = 2'd2;
    step();
    chk("pre_rst_out", int'(out), 4'b0100);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("async_rst_out", int'(out), 0);
    chk("async_rst_valid", int'(out_valid), 0);
    chk("async_rst_ready", int'(in_ready), 0);
    step();
    rst = 1'b0;
    step();

    // scan sweep, DWELL=4, with wrap at cycle 16
    mode = 1'b1; in_valid = 1'b1; sel = 2'd3;
    for (int c = 0; c <= 16; c++) begin
      step();
      chk("scan_out", int'(out), 1 << ((c / 4) % 4));
      chk("scan_idx", int'(scan_idx), (c / 4) % 4);
      chk("scan_busy", int'(busy), 1);
      chk("scan_ready", int'(in_ready), 0);
    end
    chk("scan_wrap", int'(out), 4'b0001);
    repeat (8) step();
    chk("scan_at_0100", int'(out), 4'b0100);

    // scan exit drops the offered transfer
    mode = 1'b0;
    #1;
    chk("exit_ready_blocked", int'(in_ready), 0);
    step();
    chk("exit_out", int'(out), 0);
    chk("exit_busy", int'(busy), 0);
    chk("exit_ready_back", int'(in_ready), 1);
    in_valid = 1'b0;
    step();

    // enable drop mid-scan
    mode = 1'b1;
    repeat (6) step();
    chk("abort_pre_idx", int'(scan_idx), 1);
    enable = 1'b0;
    step();
    chk("abort_out", int'(out), 0);
    chk("abort_idx", int'(scan_idx), 0);
    chk("abort_busy", int'(busy), 0);
    step(); step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
